port_group_sequencer: RTL and testbench

Per-port-group sequencer that sits on the lane side of the vector control unit's port allocator. One instance per write-port group. It accepts a one-cycle `start_i` from the allocator and latches the instruction's element count and VRF row addresses. It then issues one VRF read beat per cycle, tracks each beat through a fixed-latency execution pipeline, and issues the matching VRF write beats. When the last write has retired, it raises `port_rdy_o`, the per-group ready the allocator consumes.

---
 rtl/v_cu_pkg.sv | 9 +
 rtl/valid_pipe.sv | 16 +
 rtl/port_group_sequencer.sv | 89 ++++++++
 tb/tb_port_group_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/v_cu_pkg.sv
// v_cu_pkg: shared FSM state type, lane/latency defaults and beat-count helper for the port sequencers
package v_cu_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} port_seq_state_e;
  localparam int LANES_DEF = 8;
  localparam int PIPE_LAT_DEF = 4;
  function automatic logic [31:0] beats_of(input logic [31:0] vl, input logic [31:0] lanes = 32'(LANES_DEF));
    return (vl + lanes - 32'd1) / lanes;
  endfunction
endpackage

// File: rtl/valid_pipe.sv
// valid_pipe: DEPTH-stage valid shift register that freezes while hold is high
module valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] v;
  always_ff @(posedge clk or posedge rst)
    if (rst) v <= '0;
    else if (!hold) v <= DEPTH'({v, d});
  assign q = v[DEPTH-1];
endmodule

// File: rtl/port_group_sequencer.sv
// port_group_sequencer: per-group VRF read/write beat sequencer; define PORT_SEQ_STALL_EN to honour stall_i
module port_group_sequencer
  import v_cu_pkg::*;
#(
  parameter int LANES      = LANES_DEF,
  parameter int VL_W       = 12,
  parameter int VRF_ADDR_W = 9,
  parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [VL_W-1:0]       vl_i,
  input  logic [VRF_ADDR_W-1:0] rd_base_i,
  input  logic [VRF_ADDR_W-1:0] wr_base_i,
  input  logic                  stall_i,
  output logic                  port_rdy_o,
  output logic                  rd_en_o,
  output logic [VRF_ADDR_W-1:0] rd_addr_o,
  output logic                  wr_en_o,
  output logic [VRF_ADDR_W-1:0] wr_addr_o,
  output logic [LANES-1:0]      wr_lane_mask_o,
  output logic                  busy_o
);
  localparam logic [VL_W:0] ONE = (VL_W+1)'(1);
  port_seq_state_e state, state_nx;
  logic stall, pipe_tail, rd_last, wr_last;
  logic [VL_W:0] beats_w, beats_q, rd_cnt, wr_cnt;
  logic [VL_W-1:0] rem_w, rem_q;
  logic [VRF_ADDR_W-1:0] rd_base_q, wr_base_q;
`ifdef PORT_SEQ_STALL_EN
  assign stall = stall_i;
`else
  logic unused_stall;
  assign unused_stall = stall_i;
  assign stall = 1'b0;
`endif
  assign beats_w = (VL_W+1)'(beats_of(32'(vl_i), 32'(LANES)));
  assign rem_w = VL_W'(32'(vl_i) % 32'(LANES));
  assign port_rdy_o = state == IDLE;
  assign busy_o = ~port_rdy_o;
  assign rd_en_o = state == READ && !stall;
  assign wr_en_o = pipe_tail && !stall;
  assign rd_last = rd_cnt == beats_q - ONE;
  assign wr_last = wr_cnt == beats_q - ONE;
  assign rd_addr_o = rd_en_o ? rd_base_q + VRF_ADDR_W'(rd_cnt) : '0;
  assign wr_addr_o = wr_en_o ? wr_base_q + VRF_ADDR_W'(wr_cnt) : '0;
  // a partial final beat keeps only the low rem lanes
  assign wr_lane_mask_o = !wr_en_o ? '0 :
                          (wr_last && rem_q != '0) ? {LANES{1'b1}} >> (32'(LANES) - 32'(rem_q)) : '1;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && start_i && vl_i != '0) ? READ :
               (state == READ && rd_en_o && rd_last)     ? DRAIN :
               (state == DRAIN && wr_en_o && wr_last)    ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      beats_q <= '0;
      rem_q <= '0;
      rd_base_q <= '0;
      wr_base_q <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (state == IDLE && start_i) begin
      beats_q <= beats_w;
      rem_q <= rem_w;
      rd_base_q <= rd_base_i;
      wr_base_q <= wr_base_i;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_en_o) rd_cnt <= rd_cnt + ONE;
      if (wr_en_o) wr_cnt <= wr_cnt + ONE;
    end
  valid_pipe #(.DEPTH(PIPE_LAT)) u_valid_pipe (
    .clk (clk),
    .rst (rst),
    .hold(stall),
    .d   (rd_en_o),
    .q   (pipe_tail)
  );
`ifndef SYNTHESIS
  a_start_only_idle: assert property (@(posedge clk) disable iff (rst) !(start_i && state != IDLE));
`endif
endmodule

// File: tb/tb_port_group_sequencer.sv
// tb_port_group_sequencer: table-driven cycle checks plus back-to-back and mid-operation reset sequences
module tb_port_group_sequencer;
  localparam int NC = 14;
  localparam int PIPE_LAT = 4;
`ifdef PORT_SEQ_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, start_i, stall_i;
  logic [11:0] vl_i;
  logic [8:0] rd_base_i, wr_base_i, rd_addr_o, wr_addr_o;
  logic port_rdy_o, rd_en_o, wr_en_o, busy_o;
  logic [7:0] wr_lane_mask_o;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [11:0] vl;
    logic [8:0]  rb;
    logic [8:0]  wb;
    logic [15:0] stall;
    int          rdy;
  } vec_t;
  vec_t vecs [8];

  port_group_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .vl_i(vl_i), .rd_base_i(rd_base_i),
    .wr_base_i(wr_base_i), .stall_i(stall_i), .port_rdy_o(port_rdy_o), .rd_en_o(rd_en_o),
    .rd_addr_o(rd_addr_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_lane_mask_o(wr_lane_mask_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (port_rdy_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle port_rdy_o", 32'(port_rdy_o), 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic e_rd [NC], e_wr [NC], e_rdy [NC];
    logic [8:0] e_ra [NC], e_wa [NC];
    logic [7:0] e_m [NC];
    bit st [NC];
    int beats, rem, nrd, last_w, cnt, first;
    logic [29:0] got, want;
    beats = (int'(v.vl) + 7) / 8;
    rem = int'(v.vl) % 8;
    for (int c = 0; c < NC; c++) begin
      st[c] = STALL_EN && v.stall[c];
      e_rd[c] = 0; e_wr[c] = 0; e_ra[c] = 0; e_wa[c] = 0; e_m[c] = 0;
    end
    nrd = 0;
    last_w = 0;
    for (int c = 1; c < NC; c++)
      if (!st[c] && nrd < beats) begin
        e_rd[c] = 1;
        e_ra[c] = v.rb + 9'(nrd);
        cnt = 0;
        for (int w = c; w < NC; w++) begin
          if (cnt >= PIPE_LAT && !st[w]) begin
            e_wr[w] = 1;
            e_wa[w] = v.wb + 9'(nrd);
            e_m[w] = (nrd == beats - 1 && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
            last_w = w;
            break;
          end
          if (!st[w]) cnt++;
        end
        nrd++;
      end
    for (int c = 0; c < NC; c++) e_rdy[c] = c > last_w;
    wait_idle();
    @(posedge clk);
    #1;
    start_i = 1; vl_i = v.vl; rd_base_i = v.rb; wr_base_i = v.wb; stall_i = v.stall[0];
    first = -1;
    for (int c = 1; c < NC; c++) begin
      @(posedge clk);
      #1;
      start_i = 0;
      stall_i = v.stall[c];
      @(negedge clk);
      got = {port_rdy_o, busy_o, rd_en_o, e_rd[c] ? rd_addr_o : 9'd0,
             wr_en_o, e_wr[c] ? wr_addr_o : 9'd0, wr_lane_mask_o};
      want = {e_rdy[c], ~e_rdy[c], e_rd[c], e_ra[c], e_wr[c], e_wa[c], e_m[c]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL vec%0d cycle%0d {rdy,busy,rd_en,rd_addr,wr_en,wr_addr,mask} got=%h want=%h",
                 idx, c, got, want);
      end
      if (first < 0 && port_rdy_o === 1'b1) first = c;
    end
    stall_i = 0;
    check($sformatf("vec%0d ready_cycle", idx), 32'(first), 32'(v.rdy));
  endtask

  initial begin
    rst = 1; start_i = 0; vl_i = 0; rd_base_i = 0; wr_base_i = 0; stall_i = 0;
    vecs[0] = '{12'd16, 9'd10,  9'd40,  16'h0000, 7};
    vecs[1] = '{12'd13, 9'd5,   9'd20,  16'h0000, 7};
    vecs[2] = '{12'd0,  9'd33,  9'd44,  16'h0000, 1};
    vecs[3] = '{12'd24, 9'd100, 9'd200, 16'h000C, STALL_EN ? 10 : 8};
    vecs[4] = '{12'd16, 9'h1FF, 9'h1FE, 16'h0000, 7};
    vecs[5] = '{12'd1,  9'd7,   9'd9,   16'h0000, 6};
    vecs[6] = '{12'd17, 9'd2,   9'h1FF, 16'h0000, 8};
    vecs[7] = '{12'd9,  9'd64,  9'd128, 16'h0000, 7};
    #12;
    check("reset outputs", {22'd0, port_rdy_o, busy_o, rd_en_o, wr_en_o, rd_addr_o == 9'd0,
          wr_addr_o == 9'd0, wr_lane_mask_o == 8'd0}, {22'd0, 7'b1000111});
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
    // back-to-back: second start lands in the single ready cycle
    wait_idle();
    @(posedge clk);
    #1;
    start_i = 1; vl_i = 12'd8; rd_base_i = 9'd3; wr_base_i = 9'd4;
    for (int c = 1; c < 6; c++) begin
      @(posedge clk);
      #1;
      start_i = 0;
    end
    @(posedge clk);
    #1;
    check("b2b ready at cycle 6", 32'(port_rdy_o), 32'd1);
    start_i = 1; vl_i = 12'd16; rd_base_i = 9'd30; wr_base_i = 9'd90;
    @(posedge clk);
    #1;
    start_i = 0;
    @(negedge clk);
    check("b2b second read", {20'd0, port_rdy_o, rd_en_o, rd_addr_o, 1'b0}, {20'd0, 1'b0, 1'b1, 9'd30, 1'b0});
    // mid-operation reset of a 4-beat instruction
    wait_idle();
    @(posedge clk);
    #1;
    start_i = 1; vl_i = 12'd32; rd_base_i = 9'd50; wr_base_i = 9'd60;
    @(posedge clk);
    #1;
    start_i = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre-reset read cycle3", {23'd0, rd_en_o, rd_addr_o}, {23'd0, 1'b1, 9'd52});
    rst = 1;
    #1;
    check("abort outputs", {27'd0, port_rdy_o, busy_o, rd_en_o, wr_en_o, wr_lane_mask_o == 8'd0},
          {27'd0, 5'b10001});
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("held reset valids", {30'd0, rd_en_o, wr_en_o}, 32'd0);
    end
    rst = 0;
    run_vec(8, '{12'd8, 9'd70, 9'd80, 16'h0000, 6});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
